ycc_block_scheduler: RTL and testbench

- Sequences a full RGB frame out of the pixel memory in 8x8-block order and feeds the RGB-to-YCbCr converter, one pixel per cycle.
- Generates memory read addresses and drives the converter's enable and data inputs.
- Counts the converter's delayed enable_out to frame each converted 8x8 block for the downstream DCT stage.
- Issues a block only when downstream has signalled it can accept one.

---
 rtl/ycc_sched_pkg.sv | 18 +
 rtl/ycc_blk_addr_gen.sv | 90 +++++++++
 rtl/ycc_block_scheduler.sv | 161 ++++++++++++++++
 tb/tb_ycc_block_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ycc_sched_pkg.sv
// Shared types and constants for the YCbCr block scheduler.
// Optional feature macro used by the top level: YCC_SCHED_STALL_CNT_EN.
package ycc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ISSUE    = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } sched_state_t;

    localparam int BLK_DIM  = 8;   // block edge in pixels
    localparam int BLK_PIX  = 64;  // pixels per block
    localparam int CONV_LAT = 2;   // converter enable -> enable_out
    localparam int MEM_LAT  = 1;   // read strobe -> read data

endpackage

// File: rtl/ycc_blk_addr_gen.sv
// Pixel/line/block counters and incremental pixel-address generation.
// Walks x (fastest) then y inside an 8x8 block, then blocks left-to-right,
// top-to-bottom. Only constant adds are used, so there is no multiplier in
// the issue path.
module ycc_blk_addr_gen
    import ycc_sched_pkg::*;
#(
    parameter int IMG_W_BLKS = 80,
    parameter int IMG_H_BLKS = 60,
    parameter int ADDR_W     = 19
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start, // rewind to block (0,0)
    input  logic                          pix_adv,     // one pixel issued this cycle
    input  logic                          blk_adv,     // move to the next block
    output logic [ADDR_W-1:0]             addr,
    output logic [$clog2(IMG_W_BLKS)-1:0] blk_col,
    output logic [$clog2(IMG_H_BLKS)-1:0] blk_row,
    output logic                          last_pix,
    output logic                          last_blk
);

    localparam int COL_W = $clog2(IMG_W_BLKS);
    localparam int ROW_W = $clog2(IMG_H_BLKS);
    localparam int PIX_W = $clog2(BLK_DIM);
    localparam int IMG_W = BLK_DIM * IMG_W_BLKS;

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W - (BLK_DIM - 1));
    localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(BLK_DIM);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(BLK_DIM * IMG_W);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W_BLKS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H_BLKS - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(BLK_DIM - 1);

    logic [PIX_W-1:0]  pix_x;
    logic [PIX_W-1:0]  pix_y;
    logic [ADDR_W-1:0] blk_base;  // address of pixel (0,0) of the current block
    logic [ADDR_W-1:0] row_base;  // address of pixel (0,0) of the current block row

    assign last_pix = (pix_x == PIX_LAST) && (pix_y == PIX_LAST);
    assign last_blk = (blk_col == COL_LAST) && (blk_row == ROW_LAST);

    // Counters and running address; blk_adv reloads the address from the block base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_x    <= '0;
            pix_y    <= '0;
            blk_col  <= '0;
            blk_row  <= '0;
            blk_base <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (frame_start) begin
            pix_x    <= '0;
            pix_y    <= '0;
            blk_col  <= '0;
            blk_row  <= '0;
            blk_base <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (blk_adv) begin
            pix_x <= '0;
            pix_y <= '0;
            if (blk_col == COL_LAST) begin
                blk_col  <= '0;
                blk_row  <= blk_row + 1'b1;
                row_base <= row_base + ROW_STEP;
                blk_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP;
            end else begin
                blk_col  <= blk_col + 1'b1;
                blk_base <= blk_base + BLK_STEP;
                addr     <= blk_base + BLK_STEP;
            end
        end else if (pix_adv) begin
            pix_x <= pix_x + 1'b1;
            if (pix_x == PIX_LAST) begin
                pix_y <= pix_y + 1'b1;
                // Hold on the final pixel; the next blk_adv reloads the address.
                if (pix_y != PIX_LAST) begin
                    addr <= addr + LINE_STEP;
                end
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ycc_block_scheduler.sv
// Reads an RGB frame from pixel memory in 8x8-block order, feeds the
// RGB-to-YCbCr converter one pixel per cycle and frames each converted block
// for the DCT stage. Optional macro YCC_SCHED_STALL_CNT_EN adds the
// stall_cycles counter output.
//
// Handshake: blk_ready is a level from downstream meaning "a whole 64-pixel
// block can be accepted". It is sampled only in WAIT_RDY; once a block starts
// issuing it runs to completion because the converter cannot be stalled.
module ycc_block_scheduler
    import ycc_sched_pkg::*;
#(
    parameter int IMG_W_BLKS = 80,
    parameter int IMG_H_BLKS = 60,
    parameter int ADDR_W     = 19
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          frame_done,
    input  logic                          blk_ready,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [23:0]                   mem_rd_data,
    output logic                          conv_enable,
    output logic [23:0]                   conv_data,
    input  logic                          conv_valid,
    output logic                          blk_first,
    output logic                          blk_last,
    output logic [$clog2(IMG_W_BLKS)-1:0] blk_col,
    output logic [$clog2(IMG_H_BLKS)-1:0] blk_row,
`ifdef YCC_SCHED_STALL_CNT_EN
    output logic [31:0]                   stall_cycles,
`endif
    output sched_state_t                  dbg_state
);

    localparam logic [5:0] CNT_LAST = 6'(BLK_PIX - 1);

    sched_state_t state;
    sched_state_t state_nxt;
    logic [5:0]   out_cnt;
    logic         frame_start;
    logic         blk_adv;
    logic         last_pix;
    logic         last_blk;
    logic         blk_out_done;
    logic         in_frame;

    ycc_blk_addr_gen #(
        .IMG_W_BLKS (IMG_W_BLKS),
        .IMG_H_BLKS (IMG_H_BLKS),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_adv     (mem_rd_en),
        .blk_adv     (blk_adv),
        .addr        (mem_addr),
        .blk_col     (blk_col),
        .blk_row     (blk_row),
        .last_pix    (last_pix),
        .last_blk    (last_blk)
    );

    assign blk_out_done = conv_valid && (out_cnt == CNT_LAST);
    assign in_frame     = (state == ISSUE) || (state == DRAIN);

    assign dbg_state  = state;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign mem_rd_en  = (state == ISSUE);
    assign conv_data  = mem_rd_data;
    // Framing flags only while a block is in flight, so stray converter
    // outputs after an abort never look like block boundaries.
    assign blk_first  = conv_valid && in_frame && (out_cnt == '0);
    assign blk_last   = conv_valid && in_frame && (out_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and block-sequencing strobes.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        blk_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = WAIT_RDY;
                    frame_start = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (blk_ready) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (last_pix) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (blk_out_done) begin
                    if (last_blk) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT_RDY;
                        blk_adv   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Converter enable follows the read strobe by the memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_enable <= 1'b0;
        end else begin
            conv_enable <= mem_rd_en;
        end
    end

    // Position of the next converted pixel within its block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (conv_valid) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

`ifdef YCC_SCHED_STALL_CNT_EN
    // Saturating count of cycles spent waiting on downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (frame_start) begin
            stall_cycles <= '0;
        end else if ((state == WAIT_RDY) && !blk_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ycc_block_scheduler.sv
// Bench for ycc_block_scheduler on a 2x2-block (16x16 pixel) image.
// Optional macro YCC_SCHED_STALL_CNT_EN enables the stall_cycles checks.
`timescale 1ns/1ps
module tb_ycc_block_scheduler;
    import ycc_sched_pkg::*;

    localparam int WB    = 2;
    localparam int HB    = 2;
    localparam int AW    = 19;
    localparam int IMG_W = 8 * WB;
    localparam int FRAME_EDGES = 4 * 68 + 1;  // start edge through DONE visible

    // ---------------- clock / reset ----------------
    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic start     = 1'b0;
    logic blk_ready = 1'b0;

    always #5 clk = ~clk;

    logic          busy;
    logic          frame_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rd_data = '0;
    logic          conv_enable;
    logic [23:0]   conv_data;
    logic          conv_valid;
    logic          blk_first;
    logic          blk_last;
    logic [0:0]    blk_col;
    logic [0:0]    blk_row;
    sched_state_t  dbg_state;
`ifdef YCC_SCHED_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    ycc_block_scheduler #(
        .IMG_W_BLKS (WB),
        .IMG_H_BLKS (HB),
        .ADDR_W     (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .blk_ready    (blk_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .conv_enable  (conv_enable),
        .conv_data    (conv_data),
        .conv_valid   (conv_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .blk_col      (blk_col),
        .blk_row      (blk_row),
`ifdef YCC_SCHED_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- models ----------------
    function automatic logic [23:0] pix_of(input logic [AW-1:0] a);
        logic [23:0] t;
        t = 24'(a);
        return (t * 24'd97) ^ 24'h5a3c1e;
    endfunction

    // Pixel memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= pix_of(mem_addr);
    end

    // Converter: enable_out and data two cycles after enable/data_in.
    logic        cv1;
    logic [23:0] cd1;
    logic [23:0] cdata;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cv1 <= 1'b0; conv_valid <= 1'b0; cd1 <= '0; cdata <= '0;
        end else begin
            cv1 <= conv_enable; conv_valid <= cv1;
            cd1 <= conv_data;   cdata <= cd1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic [23:0]   exp_data_q[$];
    int            rd_cyc_q[$];
    int cyc = 0;
    int k = 0;
    int n_first = 0;
    int n_last = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push_frame();
        logic [AW-1:0] a;
        for (int br = 0; br < HB; br++)
            for (int bc = 0; bc < WB; bc++)
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++) begin
                        a = AW'((br * 8 + y) * IMG_W + bc * 8 + x);
                        exp_q.push_back(a);
                        exp_data_q.push_back(pix_of(a));
                    end
    endtask

    task automatic sample();
        if (rst) return;
        if (mem_rd_en) begin
            if (exp_q.size() == 0) check("addr_extra", 1, 0);
            else check("mem_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
            rd_cyc_q.push_back(cyc);
        end
        if (conv_valid) begin
            if (rd_cyc_q.size() == 0) check("valid_extra", 1, 0);
            else check("conv_lat", 32'(cyc - rd_cyc_q.pop_front()), 3);
            if (exp_data_q.size() == 0) check("data_extra", 1, 0);
            else check("conv_data", 32'(cdata), 32'(exp_data_q.pop_front()));
            check("blk_first", 32'(blk_first), 32'((k % 64) == 0));
            check("blk_last", 32'(blk_last), 32'((k % 64) == 63));
            n_first += int'(blk_first);
            n_last  += int'(blk_last);
            k++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic run_frame(input int stall_n, input bit restart_mid);
        int  n;
        int  wcnt;
        bit  done;
        push_frame();
        k = 0; n_first = 0; n_last = 0;
        blk_ready = 1'b1;
        start = 1'b1;
        n = 0; wcnt = 0; done = 1'b0;
        while (!done && n < 2000) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (restart_mid && n == 100) start = 1'b1;
            if (restart_mid && n == 101) start = 1'b0;
            if (stall_n > 0 && n == 80) blk_ready = 1'b0;
            if (dbg_state == WAIT_RDY && !blk_ready) begin
                if (wcnt == stall_n) blk_ready = 1'b1;
                else begin
                    check("stall_no_rd", 32'(mem_rd_en), 0);
                    wcnt++;
                end
            end
            if (frame_done) begin
                done = 1'b1;
                check("done_after_256", k, 256);
            end
        end
        check("frame_done_seen", 32'(done), 1);
        check("frame_len", n, FRAME_EDGES + stall_n);
        tick();
        check("done_pulse", 32'(frame_done), 0);
        check("idle_busy", 32'(busy), 0);
        check("addr_q_empty", exp_q.size(), 0);
        check("data_q_empty", exp_data_q.size(), 0);
        check("n_first", n_first, 4);
        check("n_last", n_last, 4);
`ifdef YCC_SCHED_STALL_CNT_EN
        check("stall_cycles", stall_cycles, stall_n);
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_conv_en"}, 32'(conv_enable), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_col"}, 32'(blk_col), 0);
        check({tag, "_row"}, 32'(blk_row), 0);
        check({tag, "_first"}, 32'(blk_first), 0);
        check({tag, "_last"}, 32'(blk_last), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
`ifdef YCC_SCHED_STALL_CNT_EN
        check({tag, "_stall"}, stall_cycles, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        tick();

        run_frame(0, 1'b0);   // plain frame, ready always high
        run_frame(10, 1'b0);  // downstream holds off block 2 for 10 cycles
        run_frame(0, 1'b1);   // stray start mid-frame is ignored

        // Asynchronous abort during block 1 issue, then a clean restart.
        push_frame();
        k = 0;
        blk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (90) tick();
        check("abort_in_issue", 32'(mem_rd_en), 1);
        #2 rst = 1'b1;
        #1 check_quiet("abort");
        exp_q.delete();
        exp_data_q.delete();
        rd_cyc_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_frame(0, 1'b0);

        // start and reset together: reset wins.
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start_busy", 32'(busy), 0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_start_idle", 32'(dbg_state), 32'(IDLE));
        check("rst_start_busy2", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
